// File: rtl/micro_uaz_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and
// default reset PC / halt opcode values.
package micro_uaz_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [7:0] RESET_PC_DEFAULT    = 8'h00;
   localparam logic [8:0] HALT_OPCODE_DEFAULT = 9'h1FF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, instruction memory port and decoder port.
// Optional FETCH_BRANCH_CHECK_EN adds the o_Error flag.
interface fetch_sequencer_if;
   import micro_uaz_pkg::*;

   logic       i_Start;
   logic       i_Stall;
   logic       i_Branch_Taken;
   logic [8:0] i_Branch_Target;
   logic [8:0] i_Instruction_Data;
   logic       i_Ready;
   logic [8:0] o_Address;
   logic [8:0] o_Instruction;
   logic       o_Valid;
   logic [7:0] o_Pc;
   logic       o_Halted;
   state_t     o_State;
`ifdef FETCH_BRANCH_CHECK_EN
   logic       o_Error;
`endif

   // Decoder handshake: a word transfers on a rising edge where o_Valid and
   // i_Ready are both high; o_Instruction/o_Pc hold while o_Valid && !i_Ready.
   modport master (
      input  i_Start, i_Stall, i_Branch_Taken, i_Branch_Target,
             i_Instruction_Data, i_Ready,
      output o_Address, o_Instruction, o_Valid, o_Pc, o_Halted, o_State
`ifdef FETCH_BRANCH_CHECK_EN
      , output o_Error
`endif
   );

   modport slave (
      output i_Start, i_Stall, i_Branch_Taken, i_Branch_Target,
             i_Instruction_Data, i_Ready,
      input  o_Address, o_Instruction, o_Valid, o_Pc, o_Halted, o_State
`ifdef FETCH_BRANCH_CHECK_EN
      , input o_Error
`endif
   );

endinterface

// File: rtl/pc_register.sv
// 8-bit program counter with load, increment and hold; load wins over increment.
module pc_register
   import micro_uaz_pkg::*;
#(
   parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       inc,
   input  logic [7:0] load_value,
   output logic [7:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_value;
      end else if (inc) begin
         pc <= pc + 8'd1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/VALID/HALT FSM with registered decoder outputs.
// Define FETCH_BRANCH_CHECK_EN to trap branches whose target has bit 8 set.
module fetch_sequencer
   import micro_uaz_pkg::*;
#(
   parameter logic [7:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [8:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset_n,
   fetch_sequencer_if.master    bus
);

   state_t     state;
   logic [8:0] instr_q;
   logic [7:0] pc_q;
   logic       valid_q;
   logic       halted_q;
   logic       error_q;
   logic [7:0] pc;
   logic       branch_hit;
   logic       branch_err;
   logic       capture;
   logic       restart;
   logic       pc_load;
   logic [7:0] pc_load_value;

   // Branches only matter while the fetch stream is running.
   assign branch_hit = bus.i_Branch_Taken && ((state == FETCH) || (state == VALID));

`ifdef FETCH_BRANCH_CHECK_EN
   assign branch_err  = branch_hit && bus.i_Branch_Target[8];
   assign bus.o_Error = error_q;
`else
   logic [1:0] unused_bits;
   assign branch_err  = 1'b0;
   assign unused_bits = {bus.i_Branch_Target[8], error_q};
`endif

   assign capture = !branch_hit && !bus.i_Stall &&
                    ((state == FETCH) ||
                     ((state == VALID) && bus.i_Ready && (instr_q != HALT_OPCODE)));
   assign restart = !branch_hit && !bus.i_Stall && (state == HALT) && bus.i_Start;

   assign pc_load       = (branch_hit && !branch_err) || restart;
   assign pc_load_value = restart ? RESET_PC : bus.i_Branch_Target[7:0];

   pc_register #(.RESET_PC(RESET_PC)) u_pc (
      .clk        (i_Clk),
      .rst_n      (i_Reset_n),
      .load       (pc_load),
      .inc        (capture),
      .load_value (pc_load_value),
      .pc         (pc)
   );

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state    <= IDLE;
         instr_q  <= 9'h000;
         pc_q     <= 8'h00;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else if (branch_hit) begin
         // The presented word is dropped even if the decoder accepts it now.
         valid_q <= 1'b0;
         if (branch_err) begin
            state    <= HALT;
            halted_q <= 1'b1;
            error_q  <= 1'b1;
         end else begin
            state <= FETCH;
         end
      end else if (!bus.i_Stall) begin
         case (state)
            IDLE: begin
               if (bus.i_Start) begin
                  state   <= FETCH;
                  error_q <= 1'b0;
               end
            end
            FETCH, VALID: begin
               if (capture) begin
                  instr_q <= bus.i_Instruction_Data;
                  pc_q    <= pc;
                  valid_q <= 1'b1;
                  state   <= VALID;
               end else if (bus.i_Ready) begin
                  valid_q  <= 1'b0;
                  halted_q <= 1'b1;
                  state    <= HALT;
               end
            end
            HALT: begin
               if (bus.i_Start) begin
                  state    <= FETCH;
                  halted_q <= 1'b0;
                  error_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.o_Address     = {1'b0, pc};
   assign bus.o_Instruction = instr_q;
   assign bus.o_Valid       = valid_q;
   assign bus.o_Pc          = pc_q;
   assign bus.o_Halted      = halted_q;
   assign bus.o_State       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expectations follow the
// FETCH_BRANCH_CHECK_EN setting used for the build.
module tb_fetch_sequencer;
   import micro_uaz_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [8:0] mem [256];
   int         total;
   int         bad;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   assign bus.i_Instruction_Data = mem[bus.o_Address[7:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_Start = 1'b0;
      bus.i_Stall = 1'b0;
      bus.i_Branch_Taken = 1'b0;
      bus.i_Branch_Target = 9'h000;
      bus.i_Ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Leaves the sequencer in VALID presenting word 0 (9'h011, pc 0).
   task automatic start_stream();
      bus.i_Start = 1'b1;
      bus.i_Ready = 1'b1;
      step();
      bus.i_Start = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++; if (bus.o_State !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", bus.o_State, IDLE); end
      do_reset();
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", bus.o_Valid); end
      total++; if (bus.o_Instruction !== 9'h000) begin bad++; $display("FAIL rst_instr got=%h exp=000", bus.o_Instruction); end
      total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", bus.o_Pc); end
      total++; if (bus.o_Halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0b exp=0", bus.o_Halted); end
      total++; if (bus.o_Address !== 9'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", bus.o_Address); end
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h040;
      step();
      bus.i_Branch_Taken = 1'b0;
      total++; if (bus.o_State !== IDLE) begin bad++; $display("FAIL idle_branch_state got=%0d exp=%0d", bus.o_State, IDLE); end
      total++; if (bus.o_Address !== 9'h000) begin bad++; $display("FAIL idle_branch_addr got=%h exp=000", bus.o_Address); end
   endtask

   task automatic test_basic();
      do_reset();
      bus.i_Start = 1'b1;
      bus.i_Ready = 1'b1;
      step();
      bus.i_Start = 1'b0;
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL basic_valid_c1 got=%0b exp=0", bus.o_Valid); end
      total++; if (bus.o_State !== FETCH) begin bad++; $display("FAIL basic_state_c1 got=%0d exp=%0d", bus.o_State, FETCH); end
      step();
      total++; if (bus.o_Valid !== 1'b1) begin bad++; $display("FAIL basic_valid_c2 got=%0b exp=1", bus.o_Valid); end
      total++; if (bus.o_Instruction !== 9'h011) begin bad++; $display("FAIL basic_instr0 got=%h exp=011", bus.o_Instruction); end
      total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL basic_pc0 got=%h exp=00", bus.o_Pc); end
      step();
      total++; if (bus.o_Instruction !== 9'h022) begin bad++; $display("FAIL basic_instr1 got=%h exp=022", bus.o_Instruction); end
      total++; if (bus.o_Pc !== 8'h01) begin bad++; $display("FAIL basic_pc1 got=%h exp=01", bus.o_Pc); end
      step();
      total++; if (bus.o_Instruction !== 9'h058) begin bad++; $display("FAIL basic_instr2 got=%h exp=058", bus.o_Instruction); end
      total++; if (bus.o_Address !== 9'h003) begin bad++; $display("FAIL basic_addr3 got=%h exp=003", bus.o_Address); end
   endtask

   task automatic test_ready_hold();
      do_reset();
      start_stream();
      bus.i_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus.o_Instruction !== 9'h011) begin bad++; $display("FAIL hold_instr c%0d got=%h exp=011", i, bus.o_Instruction); end
         total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL hold_pc c%0d got=%h exp=00", i, bus.o_Pc); end
         total++; if (bus.o_Address !== 9'h001) begin bad++; $display("FAIL hold_addr c%0d got=%h exp=001", i, bus.o_Address); end
         total++; if (bus.o_Valid !== 1'b1) begin bad++; $display("FAIL hold_valid c%0d got=%0b exp=1", i, bus.o_Valid); end
      end
      bus.i_Ready = 1'b1;
      step();
      total++; if (bus.o_Instruction !== 9'h022) begin bad++; $display("FAIL hold_resume_instr got=%h exp=022", bus.o_Instruction); end
      total++; if (bus.o_Pc !== 8'h01) begin bad++; $display("FAIL hold_resume_pc got=%h exp=01", bus.o_Pc); end
   endtask

   task automatic test_stall();
      do_reset();
      start_stream();
      bus.i_Stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL stall_pc c%0d got=%h exp=00", i, bus.o_Pc); end
         total++; if (bus.o_Address !== 9'h001) begin bad++; $display("FAIL stall_addr c%0d got=%h exp=001", i, bus.o_Address); end
         total++; if (bus.o_State !== VALID) begin bad++; $display("FAIL stall_state c%0d got=%0d exp=%0d", i, bus.o_State, VALID); end
      end
      bus.i_Stall = 1'b0;
      step();
      total++; if (bus.o_Pc !== 8'h01) begin bad++; $display("FAIL stall_release_pc got=%h exp=01", bus.o_Pc); end
   endtask

   task automatic test_branch();
      do_reset();
      start_stream();
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h080;
      step();
      bus.i_Branch_Taken = 1'b0;
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL br_valid_drop got=%0b exp=0", bus.o_Valid); end
      total++; if (bus.o_Address !== 9'h080) begin bad++; $display("FAIL br_addr got=%h exp=080", bus.o_Address); end
      step();
      total++; if (bus.o_Valid !== 1'b1) begin bad++; $display("FAIL br_valid_back got=%0b exp=1", bus.o_Valid); end
      total++; if (bus.o_Pc !== 8'h80) begin bad++; $display("FAIL br_pc got=%h exp=80", bus.o_Pc); end
      total++; if (bus.o_Instruction !== 9'h0DA) begin bad++; $display("FAIL br_instr got=%h exp=0da", bus.o_Instruction); end
      bus.i_Stall = 1'b1;
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h010;
      step();
      bus.i_Branch_Taken = 1'b0;
      bus.i_Stall = 1'b0;
      total++; if (bus.o_State !== FETCH) begin bad++; $display("FAIL br_over_stall_state got=%0d exp=%0d", bus.o_State, FETCH); end
      total++; if (bus.o_Address !== 9'h010) begin bad++; $display("FAIL br_over_stall_addr got=%h exp=010", bus.o_Address); end
      step();
      total++; if (bus.o_Pc !== 8'h10) begin bad++; $display("FAIL br_over_stall_pc got=%h exp=10", bus.o_Pc); end
   endtask

   task automatic test_halt();
      do_reset();
      start_stream();
      for (int i = 0; i < 5; i++) step();
      total++; if (bus.o_Pc !== 8'h05) begin bad++; $display("FAIL halt_word_pc got=%h exp=05", bus.o_Pc); end
      total++; if (bus.o_Instruction !== 9'h1FF) begin bad++; $display("FAIL halt_word got=%h exp=1ff", bus.o_Instruction); end
      step();
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%0b exp=0", bus.o_Valid); end
      total++; if (bus.o_Halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0b exp=1", bus.o_Halted); end
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h030;
      step();
      bus.i_Branch_Taken = 1'b0;
      total++; if (bus.o_State !== HALT) begin bad++; $display("FAIL halt_branch_state got=%0d exp=%0d", bus.o_State, HALT); end
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL halt_once got=%0b exp=0", bus.o_Valid); end
      bus.i_Start = 1'b1;
      step();
      bus.i_Start = 1'b0;
      total++; if (bus.o_Halted !== 1'b0) begin bad++; $display("FAIL restart_halted got=%0b exp=0", bus.o_Halted); end
      total++; if (bus.o_Address !== 9'h000) begin bad++; $display("FAIL restart_addr got=%h exp=000", bus.o_Address); end
      step();
      total++; if (bus.o_Instruction !== 9'h011) begin bad++; $display("FAIL restart_instr got=%h exp=011", bus.o_Instruction); end
      total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL restart_pc got=%h exp=00", bus.o_Pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      start_stream();
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h0FE;
      step();
      bus.i_Branch_Taken = 1'b0;
      step();
      total++; if (bus.o_Pc !== 8'hFE) begin bad++; $display("FAIL wrap_pc_fe got=%h exp=fe", bus.o_Pc); end
      step();
      total++; if (bus.o_Pc !== 8'hFF) begin bad++; $display("FAIL wrap_pc_ff got=%h exp=ff", bus.o_Pc); end
      total++; if (bus.o_Instruction !== 9'h0A5) begin bad++; $display("FAIL wrap_instr_ff got=%h exp=0a5", bus.o_Instruction); end
      step();
      total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL wrap_pc_00 got=%h exp=00", bus.o_Pc); end
      total++; if (bus.o_Instruction !== 9'h011) begin bad++; $display("FAIL wrap_instr_00 got=%h exp=011", bus.o_Instruction); end
   endtask

   task automatic test_branch_msb();
      do_reset();
      start_stream();
      bus.i_Branch_Taken = 1'b1;
      bus.i_Branch_Target = 9'h100;
      step();
      bus.i_Branch_Taken = 1'b0;
`ifdef FETCH_BRANCH_CHECK_EN
      total++; if (bus.o_Error !== 1'b1) begin bad++; $display("FAIL msb_error got=%0b exp=1", bus.o_Error); end
      total++; if (bus.o_Halted !== 1'b1) begin bad++; $display("FAIL msb_halted got=%0b exp=1", bus.o_Halted); end
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL msb_valid got=%0b exp=0", bus.o_Valid); end
      bus.i_Start = 1'b1;
      step();
      bus.i_Start = 1'b0;
      total++; if (bus.o_Error !== 1'b0) begin bad++; $display("FAIL msb_error_clear got=%0b exp=0", bus.o_Error); end
`else
      total++; if (bus.o_State !== FETCH) begin bad++; $display("FAIL msb_state got=%0d exp=%0d", bus.o_State, FETCH); end
      total++; if (bus.o_Address !== 9'h000) begin bad++; $display("FAIL msb_addr got=%h exp=000", bus.o_Address); end
      step();
      total++; if (bus.o_Pc !== 8'h00) begin bad++; $display("FAIL msb_pc got=%h exp=00", bus.o_Pc); end
      total++; if (bus.o_Halted !== 1'b0) begin bad++; $display("FAIL msb_halted got=%0b exp=0", bus.o_Halted); end
`endif
   endtask

   task automatic test_reset_midstream();
      do_reset();
      start_stream();
      bus.i_Ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", bus.o_Valid); end
      total++; if (bus.o_State !== IDLE) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", bus.o_State, IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++; if (bus.o_State !== IDLE) begin bad++; $display("FAIL midrst_release got=%0d exp=%0d", bus.o_State, IDLE); end
      total++; if (bus.o_Valid !== 1'b0) begin bad++; $display("FAIL midrst_valid_after got=%0b exp=0", bus.o_Valid); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      for (int a = 0; a < 256; a++) mem[a] = {1'b0, 8'(a) ^ 8'h5A};
      mem[0] = 9'h011;
      mem[1] = 9'h022;
      mem[5] = 9'h1FF;
      bus.i_Start = 1'b0;
      bus.i_Stall = 1'b0;
      bus.i_Branch_Taken = 1'b0;
      bus.i_Branch_Target = 9'h000;
      bus.i_Ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_ready_hold();
      test_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_branch_msb();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, first program-counter value after reset or restart.
REQ-002 Parameter: HALT_OPCODE, default 9'h1FF, instruction word that stops fetching.
REQ-003 i_Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_Reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_Start  input  1  level; starts or restarts fetching from RESET_PC when in IDLE or HALT.
REQ-006 i_Stall  input  1  freezes PC, state and outputs.
REQ-007 i_Branch_Taken  input  1  redirect request from execute.
REQ-008 i_Branch_Target  input  9  redirect address.
REQ-009 i_Instruction_Data  input  9  combinational read data from instruction memory.
REQ-010 i_Ready  input  1  decoder accepts o_Instruction this cycle.
REQ-011 o_Address  output  9  instruction memory address, {1'b0, PC}.
REQ-012 o_Instruction  output  9  registered instruction presented to decoder.
REQ-013 o_Valid  output  1  o_Instruction is valid.
REQ-014 o_Pc  output  8  address of the instruction currently on o_Instruction.
REQ-015 o_Halted  output  1  high in HALT state.

Function
REQ-016 States SHALL be IDLE, FETCH, VALID, HALT, encoded in 2 bits.
REQ-017 IDLE: i_Start=1 -> FETCH; PC held at RESET_PC.
REQ-018 FETCH: capture i_Instruction_Data into o_Instruction, o_Pc<=PC, PC<=PC+1, o_Valid<=1, -> VALID.
REQ-019 VALID with i_Ready=1 and o_Instruction!=HALT_OPCODE: capture next word as in REQ-018, stay VALID; throughput one instruction per cycle.
REQ-020 VALID with i_Ready=1 and o_Instruction==HALT_OPCODE: o_Valid<=0, -> HALT; no further capture.
REQ-021 VALID with i_Ready=0: hold o_Instruction, o_Pc, o_Valid, PC.
REQ-022 i_Branch_Taken=1 in FETCH or VALID: PC<=i_Branch_Target[7:0], o_Valid<=0, -> FETCH; the presented instruction is discarded even if i_Ready=1 the same cycle.
REQ-023 Priority SHALL be reset > branch > stall > handshake/capture.
REQ-024 i_Stall=1 without branch: no register changes; o_Address stays stable.
REQ-025 Branch in IDLE or HALT SHALL be ignored.
REQ-026 HALT: o_Halted=1; i_Start=1 -> PC<=RESET_PC, -> FETCH.
REQ-027 PC arithmetic SHALL be 8-bit; 8'hFF+1 wraps to 8'h00.
REQ-028 Latency: i_Start sampled in IDLE -> o_Valid high exactly 2 cycles later; branch -> o_Valid high 2 cycles after branch cycle.

Reset
REQ-029 On i_Reset_n=0, immediately: state IDLE, PC=RESET_PC, o_Instruction=9'h000, o_Pc=8'h00, o_Valid=0, o_Halted=0 (plus o_Error=0 when present).
REQ-030 Reset asserted mid-stream SHALL drop o_Valid without waiting for i_Ready; release SHALL be followed by IDLE.

Configuration
REQ-031 Macro FETCH_BRANCH_CHECK_EN: when defined, adds output o_Error (1 bit); a branch with i_Branch_Target[8]=1 sets o_Error=1, o_Valid<=0, -> HALT; o_Error clears on i_Start or reset.
REQ-032 Without FETCH_BRANCH_CHECK_EN: no o_Error port; i_Branch_Target[8] ignored, target truncated to 8 bits.

Structure
REQ-033 State encoding, HALT_OPCODE default and RESET_PC default SHALL live in shared package micro_uaz_pkg.
REQ-034 PC register with load/increment/hold SHALL be a sub-module pc_register; the FSM and output registers stay in fetch_sequencer.

Verification
REQ-035 Reset, then i_Start=1 with memory 0:9'h011, 1:9'h022 and i_Ready=1 -> o_Valid high at cycle 2 with 9'h011/o_Pc=0, next cycle 9'h022/o_Pc=1.
REQ-036 i_Ready=0 for 3 cycles while VALID -> o_Instruction, o_Pc, o_Address unchanged; resume at i_Ready=1 with no skipped word.
REQ-037 Branch to 9'h080 while i_Ready=1 -> current word discarded, o_Valid low 1 cycle, then o_Pc=8'h80.
REQ-038 Word 9'h1FF at address 5 -> delivered once, o_Halted=1 after handshake; i_Start -> refetch from address 0.
REQ-039 Sequential fetch from PC 8'hFF -> next o_Pc=8'h00.
REQ-040 With FETCH_BRANCH_CHECK_EN, branch to 9'h100 -> o_Error=1, o_Halted=1; without macro -> fetch from 8'h00.
